// File: rtl/mult_final_adder_pipe.sv
// Final carry-propagate adder for the multiplier: resolves the two Wallace rows into
// a 64-bit RV64M result over two pipeline stages, with valid/ready handshake and flush.
module mult_final_adder_pipe #(
  parameter int WIDTH = 132,
  parameter int XLEN  = 64,
  parameter int SPLIT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [WIDTH-1:0] i_row0,
  input  logic [WIDTH-1:0] i_row1,
  input  logic [2:0]       i_op,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [XLEN-1:0]  o_result
);

  localparam int HW = WIDTH - SPLIT;

  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_c1;
  logic [SPLIT-1:0] s1_lo;
  logic [HW-1:0]    s1_row0_hi;
  logic [HW-1:0]    s1_row1_hi;
  logic [2:0]       s1_op;

  logic             s1_ready;
  logic             s2_ready;
  logic             accept;
  logic             advance;
  logic [SPLIT:0]   lo_sum;
  logic [HW-1:0]    hi_sum;
  logic [XLEN-1:0]  result_next;
  logic             unused_hi_bits;

  assign s2_ready     = ~s2_valid | i_post_ready;
  assign s1_ready     = ~s1_valid | s2_ready;
  assign o_pre_ready  = s1_ready & ~i_flush;
  assign o_post_valid = s2_valid;
  assign accept       = i_pre_valid & o_pre_ready;
  // A flush blocks the s1->s2 data move so o_result keeps its last delivered value.
  assign advance      = s1_valid & s2_ready & ~i_flush;

  assign lo_sum = {1'b0, i_row0[SPLIT-1:0]} + {1'b0, i_row1[SPLIT-1:0]};
  assign hi_sum = s1_row0_hi + s1_row1_hi + {{(HW-1){1'b0}}, s1_c1};

  // Product bits above 127 carry no information for RV64M.
  assign unused_hi_bits = ^hi_sum[HW-1:XLEN];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result_next unassigned (no latch).
    result_next = s1_lo[XLEN-1:0];
    case (s1_op)
      OP_MULH, OP_MULHSU, OP_MULHU: result_next = hi_sum[XLEN-1:0];
      OP_MULW:                      result_next = {{(XLEN-32){s1_lo[31]}}, s1_lo[31:0]};
      default:                      ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: data registers are reset too, so o_result reads 0 out of reset rather than X.
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_c1      <= 1'b0;
      s1_lo      <= '0;
      s1_row0_hi <= '0;
      s1_row1_hi <= '0;
      s1_op      <= '0;
      o_result   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
      if (i_flush)       s1_valid <= 1'b0;
      else if (accept)   s1_valid <= 1'b1;
      else if (s2_ready) s1_valid <= 1'b0;

      if (i_flush)       s2_valid <= 1'b0;
      else if (s2_ready) s2_valid <= s1_valid;

      if (accept) begin
        s1_lo      <= lo_sum[SPLIT-1:0];
        s1_c1      <= lo_sum[SPLIT];
        s1_row0_hi <= i_row0[WIDTH-1:SPLIT];
        s1_row1_hi <= i_row1[WIDTH-1:SPLIT];
        s1_op      <= i_op;
      end

      if (advance) o_result <= result_next;
    end
  end

endmodule

// File: tb/tb_mult_final_adder_pipe.sv
// Directed self-checking bench for mult_final_adder_pipe: op selection, split carry,
// latency, backpressure, flush and mid-stream reset.
module tb_mult_final_adder_pipe;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_flush;
  logic         i_pre_valid;
  logic         o_pre_ready;
  logic [131:0] i_row0;
  logic [131:0] i_row1;
  logic [2:0]   i_op;
  logic         o_post_valid;
  logic         i_post_ready;
  logic [63:0]  o_result;

  int checks   = 0;
  int failures = 0;

  mult_final_adder_pipe dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_row0       (i_row0),
    .i_row1       (i_row1),
    .i_op         (i_op),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .o_result     (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Sends one beat with downstream always ready; lat is edges from accept to valid, -1 on timeout.
  task automatic run_one(input logic [131:0] r0, input logic [131:0] r1, input logic [2:0] op,
                         output logic [63:0] res, output int lat);
    int guard = 0;
    i_post_ready = 1'b1;
    i_row0 = r0;
    i_row1 = r1;
    i_op = op;
    i_pre_valid = 1'b1;
    while (!o_pre_ready && guard < 10) begin
      step();
      guard++;
    end
    step();
    i_pre_valid = 1'b0;
    lat = 1;
    while (!o_post_valid && lat < 10) begin
      step();
      lat++;
    end
    res = o_result;
    if (!o_post_valid || guard >= 10) lat = -1;
    step();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_flush = 1'b0;
    i_pre_valid = 1'b0;
    i_post_ready = 1'b0;
    i_row0 = '0;
    i_row1 = '0;
    i_op = 3'd0;
    step();
    step();
    i_rst = 1'b0;
    checks++;
    if (o_post_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b want=0", o_post_valid);
    end
    checks++;
    if (o_result !== 64'h0) begin
      failures++; $display("FAIL reset_result got=%h want=0", o_result);
    end
    checks++;
    if (o_pre_ready !== 1'b1) begin
      failures++; $display("FAIL reset_pre_ready got=%0b want=1", o_pre_ready);
    end
  endtask

  typedef struct {
    logic [131:0] r0;
    logic [131:0] r1;
    logic [2:0]   op;
    logic [63:0]  exp;
    string        name;
  } vec_t;

  task automatic test_ops();
    vec_t v[8];
    logic [63:0] res;
    int lat;
    v[0] = '{132'hF, 132'h0, 3'd0, 64'hF, "basic_mul"};
    v[1] = '{132'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 132'h1, 3'd3, 64'h2, "carry_mulhu"};
    v[2] = '{132'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 132'h1, 3'd0, 64'h0, "carry_mul"};
    v[3] = '{132'h8000_0000, 132'h0, 3'd4, 64'hFFFF_FFFF_8000_0000, "mulw_neg"};
    v[4] = '{132'h1_7FFF_FFFF, 132'h0, 3'd4, 64'h0000_0000_7FFF_FFFF, "mulw_pos"};
    v[5] = '{132'h0_1234_5678_0000_0000_0000_0000_0000_0005, 132'h0_0000_0001_0000_0000_0000_0000_0000_0003,
             3'd1, 64'h1234_5679_0000_0000, "mulh_hi"};
    v[6] = '{132'hF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 132'h1, 3'd2, 64'h0, "wrap_mulhsu"};
    v[7] = '{132'h0_AAAA_0000_0000_0000_0000_0000_0000_0021, 132'h0_0000_0000_0000_0000_0000_0000_0000_0002,
             3'd6, 64'h23, "reserved_op"};
    foreach (v[i]) begin
      run_one(v[i].r0, v[i].r1, v[i].op, res, lat);
      checks++;
      if (lat !== 2) begin
        failures++; $display("FAIL %s_latency got=%0d want=2", v[i].name, lat);
      end
      checks++;
      if (res !== v[i].exp) begin
        failures++; $display("FAIL %s_result got=%h want=%h", v[i].name, res, v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[4];
    logic [63:0] held;
    int sent = 0, recv = 0, cnt = 0, saw_block = 0, stalled = 0;
    bit acc, drn;
    for (int k = 0; k < 4; k++) exp_q[k] = 64'h1111 * (k + 1) + 64'h7;
    for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
      i_post_ready = !(cyc >= 3 && cyc <= 5);
      i_pre_valid = (sent < 4);
      i_row0 = 132'h1111 * (sent + 1);
      i_row1 = 132'h7;
      i_op = 3'd0;
      #1;
      checks++;
      if (o_pre_ready !== ((cnt < 2) || i_post_ready)) begin
        failures++; $display("FAIL b2b_pre_ready cyc=%0d got=%0b cnt=%0d", cyc, o_pre_ready, cnt);
      end
      if (!o_pre_ready) saw_block = 1;
      if (stalled) begin
        checks++;
        if (o_post_valid !== 1'b1 || o_result !== held) begin
          failures++; $display("FAIL b2b_stall_stable got=%0b/%h want=1/%h", o_post_valid, o_result, held);
        end
      end
      acc = i_pre_valid && o_pre_ready;
      drn = o_post_valid && i_post_ready;
      if (drn) begin
        checks++;
        if (o_result !== exp_q[recv]) begin
          failures++; $display("FAIL b2b_order idx=%0d got=%h want=%h", recv, o_result, exp_q[recv]);
        end
        recv++;
      end
      stalled = o_post_valid && !i_post_ready;
      held = o_result;
      if (acc) sent++;
      cnt = cnt + int'(acc) - int'(drn);
      step();
    end
    i_pre_valid = 1'b0;
    checks++;
    if (recv !== 4) begin
      failures++; $display("FAIL b2b_count got=%0d want=4", recv);
    end
    checks++;
    if (saw_block !== 1) begin
      failures++; $display("FAIL b2b_blocked got=%0d want=1", saw_block);
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat, seen = 0;
    i_post_ready = 1'b0;
    i_op = 3'd0;
    i_row1 = '0;
    i_pre_valid = 1'b1;
    i_row0 = 132'hA1;
    step();
    i_row0 = 132'hB2;
    step();
    i_row0 = 132'hC3;
    i_flush = 1'b1;
    #1;
    checks++;
    if (o_post_valid !== 1'b1 || o_result !== 64'hA1) begin
      failures++; $display("FAIL flush_setup got=%0b/%h want=1/a1", o_post_valid, o_result);
    end
    checks++;
    if (o_pre_ready !== 1'b0) begin
      failures++; $display("FAIL flush_pre_ready got=%0b want=0", o_pre_ready);
    end
    step();
    i_flush = 1'b0;
    i_pre_valid = 1'b0;
    i_post_ready = 1'b1;
    checks++;
    if (o_result !== 64'hA1) begin
      failures++; $display("FAIL flush_result_kept got=%h want=a1", o_result);
    end
    for (int k = 0; k < 4; k++) begin
      if (o_post_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL flush_no_valid got=%0d want=0", seen);
    end
    run_one(132'hD4, 132'h1, 3'd0, res, lat);
    checks++;
    if (lat !== 2 || res !== 64'hD5) begin
      failures++; $display("FAIL flush_next got=%0d/%h want=2/d5", lat, res);
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    i_post_ready = 1'b0;
    i_op = 3'd0;
    i_row1 = '0;
    i_pre_valid = 1'b1;
    i_row0 = 132'h55;
    step();
    i_row0 = 132'h66;
    step();
    i_pre_valid = 1'b0;
    checks++;
    if (o_post_valid !== 1'b1 || o_pre_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_setup got=%0b/%0b want=1/0", o_post_valid, o_pre_ready);
    end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    checks++;
    if (o_post_valid !== 1'b0 || o_result !== 64'h0 || o_pre_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid got=%0b/%h/%0b want=0/0/1", o_post_valid, o_result, o_pre_ready);
    end
    i_post_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (o_post_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL rst_mid_dropped got=%0d want=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
